// File: rtl/lemmings_fsm_array.sv
// NUM_LEM independent Lemmings walker FSMs (walk/bump/fall/dig/splat), Moore outputs.
// Optional digging is built in only when LEMMINGS_DIG_EN is defined.
module lemmings_fsm_array #(
  parameter int NUM_LEM    = 4,
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = 5
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [NUM_LEM-1:0] bump_left,
  input  logic [NUM_LEM-1:0] bump_right,
  input  logic [NUM_LEM-1:0] ground,
  input  logic [NUM_LEM-1:0] dig,
  output logic [NUM_LEM-1:0] walk_left,
  output logic [NUM_LEM-1:0] walk_right,
  output logic [NUM_LEM-1:0] aaah,
  output logic [NUM_LEM-1:0] digging,
  output logic [NUM_LEM-1:0] splat
);

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
`ifdef LEMMINGS_DIG_EN
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
`endif
    SPLAT  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(FALL_LIMIT);

`ifndef LEMMINGS_DIG_EN
  logic unused_dig;
  assign unused_dig = ^dig;
`endif

  for (genvar i = 0; i < NUM_LEM; i++) begin : g_lem
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        state_q <= WALK_L;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // cnt_d defaults to 0 so the counter only survives while falling
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
        WALK_L: begin
          if (!ground[i])         state_d = FALL_L;
`ifdef LEMMINGS_DIG_EN
          else if (dig[i])        state_d = DIG_L;
`endif
          else if (bump_left[i])  state_d = WALK_R;
        end
        WALK_R: begin
          if (!ground[i])         state_d = FALL_R;
`ifdef LEMMINGS_DIG_EN
          else if (dig[i])        state_d = DIG_R;
`endif
          else if (bump_right[i]) state_d = WALK_L;
        end
`ifdef LEMMINGS_DIG_EN
        DIG_L: if (!ground[i]) state_d = FALL_L;
        DIG_R: if (!ground[i]) state_d = FALL_R;
`endif
        FALL_L, FALL_R: begin
          if (ground[i]) begin
            if (cnt_q >= LIMIT)            state_d = SPLAT;
            else if (state_q == FALL_L)    state_d = WALK_L;
            else                           state_d = WALK_R;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
        SPLAT:   state_d = SPLAT;
        default: state_d = WALK_L;
      endcase
    end

    assign walk_left[i]  = (state_q == WALK_L);
    assign walk_right[i] = (state_q == WALK_R);
    assign aaah[i]       = (state_q == FALL_L) || (state_q == FALL_R);
    assign splat[i]      = (state_q == SPLAT);
`ifdef LEMMINGS_DIG_EN
    assign digging[i]    = (state_q == DIG_L) || (state_q == DIG_R);
`else
    assign digging[i]    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_lemmings_fsm_array.sv
// Directed plus randomized bench for lemmings_fsm_array against a per-channel game model.
module tb_lemmings_fsm_array;
  localparam int N = 4;
  localparam int FALL_LIMIT = 20;
`ifdef LEMMINGS_DIG_EN
  localparam bit DIG_EN = 1'b1;
`else
  localparam bit DIG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         areset;
  logic [N-1:0] bump_left, bump_right, ground, dig;
  logic [N-1:0] walk_left, walk_right, aaah, digging, splat;

  lemmings_fsm_array #(.NUM_LEM(N), .FALL_LIMIT(FALL_LIMIT), .CNT_W(5)) dut (
    .clk(clk), .areset(areset),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .digging(digging), .splat(splat)
  );

  always #5 clk = ~clk;

  // Game model: what the lemming is doing, which way it faces, and how long it has been airborne.
  typedef enum int {M_WALK, M_FALL, M_DIG, M_SPLAT} mode_t;
  mode_t m_mode [N];
  bit    m_right[N];
  int    m_air  [N];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_mode[c] = M_WALK; m_right[c] = 1'b0; m_air[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      case (m_mode[c])
        M_WALK: begin
          if (!ground[c]) begin m_mode[c] = M_FALL; m_air[c] = 1; end
          else if (DIG_EN && dig[c]) m_mode[c] = M_DIG;
          else if (m_right[c] ? bump_right[c] : bump_left[c]) m_right[c] = !m_right[c];
        end
        M_DIG: if (!ground[c]) begin m_mode[c] = M_FALL; m_air[c] = 1; end
        M_FALL: begin
          if (ground[c]) m_mode[c] = (m_air[c] > FALL_LIMIT) ? M_SPLAT : M_WALK;
          else m_air[c]++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e_wl, e_wr, e_ah, e_dg, e_sp;
    for (int c = 0; c < N; c++) begin
      e_wl[c] = (m_mode[c] == M_WALK) && !m_right[c];
      e_wr[c] = (m_mode[c] == M_WALK) &&  m_right[c];
      e_ah[c] = (m_mode[c] == M_FALL);
      e_dg[c] = (m_mode[c] == M_DIG);
      e_sp[c] = (m_mode[c] == M_SPLAT);
    end
    check({tag, ".walk_left"},  walk_left,  e_wl);
    check({tag, ".walk_right"}, walk_right, e_wr);
    check({tag, ".aaah"},       aaah,       e_ah);
    check({tag, ".digging"},    digging,    e_dg);
    check({tag, ".splat"},      splat,      e_sp);
  endtask

  // One clock: inputs already driven; returns at posedge+1 with outputs checked.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Reset pulse between edges: outputs must respond before the next edge.
  task automatic reset_pulse(input string tag);
    areset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    check({tag, ".all_left"}, walk_left, '1);
    #1;
    areset = 1'b0;
  endtask

  task automatic rand_inputs();
    bump_left  = N'($urandom);
    bump_right = N'($urandom);
    ground     = N'($urandom) | N'($urandom);
    dig        = N'($urandom) & N'($urandom);
  endtask

  initial begin
    int n_air;
    areset = 1'b1;
    bump_left = '0; bump_right = '0; ground = '1; dig = '0;
    model_reset();
    #2;
    check_all("rst0");
    @(posedge clk); #1;
    check_all("rst_held");
    areset = 1'b0;

    // T1: walk a bit, reset mid-walk, then one bump_left on ch0
    bump_left = 4'b0110;
    step("t1_walk");
    bump_left = '0;
    reset_pulse("t1_reset");
    bump_left = 4'b0001;
    step("t1_bump");
    check("t1_wr0", walk_right, 4'b0001);
    bump_left = '0;

    // T2: both bumps on ch0 always flip heading
    bump_left = 4'b0001; bump_right = 4'b0001;
    step("t2_a");
    check("t2_wl", walk_left, 4'b1111);
    step("t2_b");
    check("t2_wr", walk_right, 4'b0001);
    bump_left = '0; bump_right = '0;

    // T3: ch1 walks right, falls for 20 cycles, lands safely
    bump_left = 4'b0010;
    step("t3_turn");
    bump_left = '0;
    ground = 4'b1101;
    n_air = 0;
    for (int k = 0; k < 20; k++) begin
      step("t3_fall");
      if (aaah[1]) n_air++;
    end
    check_int("t3_air_cycles", n_air, 20);
    ground = '1;
    step("t3_land");
    check_int("t3_wr1", int'(walk_right[1]), 1);
    check_int("t3_sp1", int'(splat[1]), 0);

    // T4: 21-cycle fall on ch1 splats; splat holds under random inputs
    ground = 4'b1101;
    for (int k = 0; k < 21; k++) step("t4_fall");
    ground = '1;
    step("t4_land");
    check_int("t4_splat1", int'(splat[1]), 1);
    check_int("t4_others1", int'(walk_left[1] | walk_right[1] | aaah[1] | digging[1]), 0);
    for (int k = 0; k < 50; k++) begin
      rand_inputs();
      step("t4_hold");
      check_int("t4_splat_hold", int'(splat[1]), 1);
    end
    bump_left = '0; bump_right = '0; ground = '1; dig = '0;
    reset_pulse("t4_reset");
    check_int("t4_wl1", int'(walk_left[1]), 1);

    // T5: dig on ch2 takes priority over bump, then fall 3 cycles and land
    dig = 4'b0100; bump_left = 4'b0100;
    step("t5_dig");
    if (DIG_EN) check_int("t5_digging2", int'(digging[2]), 1);
    else        check_int("t5_turn2", int'(walk_right[2]), 1);
    dig = '0; bump_left = '0;
    ground = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      step("t5_fall");
      check_int("t5_aaah2", int'(aaah[2]), 1);
    end
    ground = '1;
    step("t5_land");
    if (DIG_EN) check_int("t5_wl2", int'(walk_left[2]), 1);
    else        check_int("t5_wr2", int'(walk_right[2]), 1);

    // T6: random traffic on all channels with sporadic mid-cycle resets
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      if ($urandom_range(0, 39) == 0) reset_pulse("t6_reset");
      step("t6_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
